// File: rtl/iir_biquad_seq_if.sv
// rtl/iir_biquad_seq_if.sv - sample, coefficient and result signals of the biquad
interface iir_biquad_seq_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 18
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] data_in;
  logic                     coef_wr;
  logic [2:0]               coef_sel;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_err;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  data_out;
  logic                     ovf;

  modport master (
    output in_valid, data_in, coef_wr, coef_sel, coef_data,
    input  in_ready, coef_err, out_valid, data_out, ovf
  );

  modport slave (
    input  in_valid, data_in, coef_wr, coef_sel, coef_data,
    output in_ready, coef_err, out_valid, data_out, ovf
  );
endinterface

// File: rtl/iir_biquad_seq.sv
// rtl/iir_biquad_seq.sv - second-order IIR with one time-shared multiplier and programmable coefficients
// Define IIR_SATURATE_EN to clamp out-of-range results; otherwise they wrap.
module iir_biquad_seq #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 18,
  parameter int ACC_W  = 30,
  parameter int FRAC   = 0
) (
  input logic clk,
  input logic rst,
  iir_biquad_seq_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  localparam logic signed [COEF_W-1:0] B1_RST = COEF_W'(5);
  localparam logic signed [COEF_W-1:0] A1_RST = COEF_W'(1);
  localparam logic signed [OUT_W-1:0]  Y_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0]  Y_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

  state_t state_q, state_d;
  logic [2:0] step_q, step_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] x_q, x_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [OUT_W-1:0] y1_q, y1_d, y2_q, y2_d;
  logic signed [COEF_W-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
  logic signed [OUT_W-1:0] data_out_q, data_out_d;
  logic out_valid_q, out_valid_d, ovf_q, ovf_d, coef_err_q, coef_err_d;

  logic signed [ACC_W-1:0] mul_a, mul_b, prod, shifted;
  logic [ACC_W-OUT_W:0] upper;
  logic ovf_w;
  logic signed [OUT_W-1:0] result;

  always_comb begin
    mul_a = ACC_W'(b0_q);
    mul_b = ACC_W'(x_q);
    case (step_q)
      3'd1: begin mul_a = ACC_W'(b1_q); mul_b = ACC_W'(x1_q); end
      3'd2: begin mul_a = ACC_W'(b2_q); mul_b = ACC_W'(x2_q); end
      3'd3: begin mul_a = ACC_W'(a1_q); mul_b = ACC_W'(y1_q); end
      3'd4: begin mul_a = ACC_W'(a2_q); mul_b = ACC_W'(y2_q); end
      default: ;
    endcase
  end

  assign prod    = mul_a * mul_b;
  assign shifted = acc_q >>> FRAC;
  // Result fits OUT_W only when every discarded bit matches the new sign bit.
  assign upper   = shifted[ACC_W-1:OUT_W-1];
  assign ovf_w   = !((&upper) || !(|upper));

`ifdef IIR_SATURATE_EN
  assign result = ovf_w ? (shifted[ACC_W-1] ? Y_MIN : Y_MAX) : shifted[OUT_W-1:0];
`else
  assign result = shifted[OUT_W-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    x_d         = x_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    ovf_d       = 1'b0;
    coef_err_d  = 1'b0;

    if (bus.coef_wr) begin
      if (state_q == S_IDLE && bus.coef_sel <= 3'd4) begin
        case (bus.coef_sel)
          3'd0:    b0_d = bus.coef_data;
          3'd1:    b1_d = bus.coef_data;
          3'd2:    b2_d = bus.coef_data;
          3'd3:    a1_d = bus.coef_data;
          default: a2_d = bus.coef_data;
        endcase
      end else begin
        coef_err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.data_in;
          acc_d   = '0;
          step_d  = 3'd0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        // Feedback products (steps 3 and 4) carry the minus sign of the recursion.
        acc_d  = (step_q >= 3'd3) ? acc_q - prod : acc_q + prod;
        step_d = step_q + 3'd1;
        if (step_q == 3'd4) state_d = S_OUT;
      end
      S_OUT: begin
        data_out_d  = result;
        out_valid_d = 1'b1;
        ovf_d       = ovf_w;
        x2_d        = x1_q;
        x1_d        = x_q;
        y2_d        = y1_q;
        y1_d        = result;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      b0_q        <= '0;
      b1_q        <= B1_RST;
      b2_q        <= '0;
      a1_q        <= A1_RST;
      a2_q        <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      coef_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      coef_err_q  <= coef_err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.coef_err  = coef_err_q;
endmodule

// File: tb/tb_iir_biquad_seq.sv
// tb/tb_iir_biquad_seq.sv - scoreboard bench for iir_biquad_seq (FRAC=0 and FRAC=2 instances)
module tb_iir_biquad_seq;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 18;
  localparam int ACC_W  = 30;
`ifdef IIR_SATURATE_EN
  localparam int SAT_Y = -131072;
`else
  localparam int SAT_Y = 16384;
`endif

  typedef struct packed {
    logic signed [OUT_W-1:0] y;
    logic                    ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iir_biquad_seq_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) bus0 ();
  iir_biquad_seq_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) bus1 ();

  iir_biquad_seq #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .FRAC(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  iir_biquad_seq #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .FRAC(2))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  exp_t q0[$];
  exp_t q1[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  always @(negedge clk) begin : mon0
    exp_t e;
    if (bus0.out_valid) begin
      if (q0.size() == 0) check("dut0 unexpected out_valid", 1, 0);
      else begin
        e = q0.pop_front();
        check("dut0 data_out", bus0.data_out, e.y);
        check("dut0 ovf", bus0.ovf, e.ovf);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (bus1.out_valid) begin
      if (q1.size() == 0) check("dut1 unexpected out_valid", 1, 0);
      else begin
        e = q1.pop_front();
        check("dut1 data_out", bus1.data_out, e.y);
        check("dut1 ovf", bus1.ovf, e.ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit w, input int y, input bit ov);
    exp_t e;
    e.y   = OUT_W'(y);
    e.ovf = ov;
    if (w) q1.push_back(e);
    else   q0.push_back(e);
  endtask

  task automatic wait_ready(input bit w);
    int n = 0;
    while (!(w ? bus1.in_ready : bus0.in_ready) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("in_ready timeout", 0, 1);
  endtask

  task automatic send(input bit w, input int x, input int y, input bit ov);
    wait_ready(w);
    push(w, y, ov);
    if (w) begin bus1.data_in = DATA_W'(x); bus1.in_valid = 1'b1; end
    else   begin bus0.data_in = DATA_W'(x); bus0.in_valid = 1'b1; end
    tick();
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
  endtask

  task automatic wcoef(input bit w, input int sel, input int val);
    wait_ready(w);
    if (w) begin bus1.coef_wr = 1'b1; bus1.coef_sel = 3'(sel); bus1.coef_data = COEF_W'(val); end
    else   begin bus0.coef_wr = 1'b1; bus0.coef_sel = 3'(sel); bus0.coef_data = COEF_W'(val); end
    tick();
    bus0.coef_wr = 1'b0;
    bus1.coef_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    bus0.in_valid = 1'b0; bus0.data_in = '0; bus0.coef_wr = 1'b0; bus0.coef_sel = '0; bus0.coef_data = '0;
    bus1.in_valid = 1'b0; bus1.data_in = '0; bus1.coef_wr = 1'b0; bus1.coef_sel = '0; bus1.coef_data = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", bus0.in_ready, 0);
    check("reset data_out", bus0.data_out, 0);
    check("reset out_valid", bus0.out_valid, 0);
    check("reset ovf", bus0.ovf, 0);
    check("reset coef_err", bus0.coef_err, 0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", bus0.in_ready, 1);

    // Legacy response y = 5*x[n-1] - y[n-1]
    send(0, 3, 0, 0);
    send(0, 0, 15, 0);
    send(0, 0, -15, 0);
    send(0, 0, 15, 0);

    // Held in_valid: accepted at E0, again at E7; x=2 with x1=0,y1=15 then x1=2,y1=-15
    wait_ready(0);
    push(0, -15, 0);
    push(0, 25, 0);
    bus0.data_in  = 8'sd2;
    bus0.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("in_ready after E%0d", k), bus0.in_ready, (k == 6) ? 1 : 0);
      check($sformatf("out_valid after E%0d", k), bus0.out_valid, (k == 6) ? 1 : 0);
    end
    bus0.in_valid = 1'b0;

    // b1 write during MAC is dropped: 5*2 - 25 = -15 (b1=3 would give -19)
    wait_ready(0);
    push(0, -15, 0);
    bus0.data_in  = 8'sd0;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid  = 1'b0;
    bus0.coef_wr   = 1'b1;
    bus0.coef_sel  = 3'd1;
    bus0.coef_data = 8'sd3;
    tick();
    bus0.coef_wr = 1'b0;
    check("coef_err after MAC write", bus0.coef_err, 1);
    tick();
    check("coef_err one cycle", bus0.coef_err, 0);

    wcoef(0, 6, 9);
    check("coef_err sel=6", bus0.coef_err, 1);
    tick();
    check("coef_err sel=6 clears", bus0.coef_err, 0);
    wcoef(0, 1, 5);
    check("coef_err valid write", bus0.coef_err, 0);

    // Reset at E3 abandons the sample and clears history
    wait_ready(0);
    bus0.data_in  = 8'sd9;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("data_out after mid reset", bus0.data_out, 0);
    check("out_valid after mid reset", bus0.out_valid, 0);
    send(0, 4, 0, 0);

    // Overflow: b0 written on the same edge the sample is accepted
    wcoef(0, 1, 0);
    wcoef(0, 3, -128);
    wait_ready(0);
    push(0, -16256, 0);
    bus0.coef_wr   = 1'b1;
    bus0.coef_sel  = 3'd0;
    bus0.coef_data = 8'sd127;
    bus0.data_in   = -8'sd128;
    bus0.in_valid  = 1'b1;
    tick();
    bus0.coef_wr  = 1'b0;
    bus0.in_valid = 1'b0;
    check("coef_err same-edge write", bus0.coef_err, 0);
    send(0, 0, SAT_Y, 1);

    // FRAC=2 instance: floor(35/4)=8, floor(-35/4)=-9
    wcoef(1, 0, 5);
    wcoef(1, 1, 0);
    wcoef(1, 3, 0);
    send(1, 7, 8, 0);
    send(1, -7, -9, 0);

    wait_ready(0);
    wait_ready(1);
    repeat (3) tick();
    check("dut0 outputs outstanding", q0.size(), 0);
    check("dut1 outputs outstanding", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/iir_biquad_seq.md
# iir_biquad_seq

Parametrised second-order IIR filter: `y[n] = (b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2]) >>> FRAC`. It is the successor to the team's fixed first-order IIR. It adds runtime-programmable coefficients, a valid/ready input handshake, a one-cycle output strobe, fixed-point scaling and overflow handling. One signed multiplier is time-shared across the five products under a small FSM. Reset-default coefficients reproduce the legacy filter `y[n] = 5·x[n-1] − y[n-1]`.

## Interface
Parameters:
- `DATA_W`, 8: signed input sample width.
- `COEF_W`, 8: signed coefficient width.
- `OUT_W`, 18: signed output and y-history width.
- `ACC_W`, 30: signed accumulator width. Must be ≥ OUT_W+COEF_W+3.
- `FRAC`, 0: arithmetic right shift applied to the accumulator before the output stage.

Ports:
- `clk`, in, 1: the single clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: `data_in` holds a sample.
- `in_ready`, out, 1: block can accept a sample.
- `data_in`, in, DATA_W: signed sample x[n].
- `coef_wr`, in, 1: coefficient write strobe.
- `coef_sel`, in, 3: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 are invalid.
- `coef_data`, in, COEF_W: signed coefficient value.
- `coef_err`, out, 1: one-cycle pulse when a coefficient write is rejected.
- `out_valid`, out, 1: one-cycle strobe; `data_out` is a new result.
- `data_out`, out, OUT_W: signed y[n]. Holds its value between strobes.
- `ovf`, out, 1: valid with `out_valid`; the result overflowed OUT_W.

## Operation
- FSM states: IDLE, MAC, OUT.
  - IDLE: `in_ready`=1. On `in_valid`, capture x, clear acc, set step=0, go to MAC.
  - MAC: one product per cycle, in order b0·x, b1·x1, b2·x2, −a1·y1, −a2·y2, accumulated in ACC_W. After step 4, go to OUT.
  - OUT: form the result, register `data_out`, pulse `out_valid`/`ovf`, shift history (x2←x1, x1←x, y2←y1, y1←result), return to IDLE.
- Arithmetic:
  - All operands are sign-extended to ACC_W.
  - `acc >>> FRAC` rounds toward −∞ (no rounding).
  - The stored y-history is the post-overflow-handling value, as output.
- Coefficient writes:
  - Accepted only in IDLE (`in_ready`=1) with `coef_sel` ≤ 4.
  - Writes in MAC/OUT, or with `coef_sel` ≥ 5, are dropped and `coef_err` pulses the next cycle.
  - A write and a sample accept on the same edge are both performed; that sample uses the new coefficient.
- Reset values:
  - `data_out`=0, `out_valid`=0, `ovf`=0, `coef_err`=0.
  - History and acc are 0; state is IDLE.
  - Coefficients: b0=0, b1=5, b2=0, a1=1, a2=0.
  - `in_ready`=0 while `rst` is high.
- Reset mid-operation: the in-flight sample is abandoned, with no `out_valid`. History and coefficients return to their reset values.

## Timing
- Sample accepted on edge E0. MAC products accumulate on edges E1–E5.
- On edge E6: `data_out` updates and `out_valid`=1 for the cycle after E6.
- `in_ready`:
  - low for the cycles following E0 through E6;
  - high again after E6;
  - earliest next accept is edge E7, so sustained throughput is one sample per 7 cycles.
- `in_valid` while `in_ready`=0 is ignored; the source must hold the sample.
- `coef_err` asserts for the cycle after the rejected write edge.

## Configuration
- `IIR_SATURATE_EN` defined: a shifted accumulator outside the OUT_W signed range is clamped to ±full-scale (−2^(OUT_W−1) or 2^(OUT_W−1)−1), and `ovf`=1.
- `IIR_SATURATE_EN` undefined: the low OUT_W bits are taken (two's-complement wrap), and `ovf`=1 whenever the discarded upper bits are not a sign extension.

## Test plan
- Default coefficients after reset, samples 3, 0, 0, 0 -> outputs 0, 15, −15, 15, with `ovf`=0 each time.
- Single accept at edge E0 -> `out_valid` high only after E6; `in_ready` low after E0 through E6; `in_valid` held high is accepted again at E7.
- Saturation, with b0=127, a1=−128, others 0, samples −128 then 0 -> outputs −16256 then:
  - with `IIR_SATURATE_EN`: −131072, `ovf`=1;
  - without it: 16384, `ovf`=1.
- Write b1=3 during MAC -> `coef_err` pulses one cycle, and the result uses b1=5. Write with `coef_sel`=6 in IDLE -> `coef_err` pulses.
- Assert `rst` one cycle at E3 of a sample -> no `out_valid`, `data_out`=0. The next sample x=4 with defaults gives output 0.
- Instance with FRAC=2, coefficients b0=5 and others 0, samples 7 then −7 -> outputs 8 then −9.
